sccb_master: RTL and testbench
==============================

Name: sccb_master

Overview:
- Single-clock SCCB (OV7670 camera control bus) master.
- Performs one 3-phase register write, or one 2-phase-write + 2-phase-read register read, per request.
- Drives SIOC and a tri-state SIOD split into oe/out/in; the pad and pull-up are outside the block.
- Sits under the camera controller, which sequences the OV7670 init table and user read/write requests through the start/ready handshake.

Parameters:
QUARTER, 63, clk cycles per quarter SIOC period (SIOC period = 4*QUARTER; 63 at 25 MHz gives ~99 kHz); legal >= 2
WR_ID, 8'h42, SCCB device write ID
RD_ID, 8'h43, SCCB device read ID

Ports:
clk  input  1  system clock (25 MHz nominal)
reset  input  1  synchronous, active-high reset
start_w  input  1  write request pulse; sampled only while ready=1
start_r  input  1  read request pulse; sampled only while ready=1
addr  input  8  register sub-address, latched on accepted start
wdata  input  8  write data, latched on accepted start_w
rdata  output  8  last read byte; held until next read completes
ready  output  1  1 = idle, can accept a request
sioc  output  1  SCCB clock
siod_oe  output  1  1 = drive SIOD with siod_out; 0 = release
siod_out  output  1  SIOD drive value
siod_in  input  1  SIOD pad value

Behaviour:
- Reset and idle outputs: ready=1, sioc=1, siod_oe=1, siod_out=1, rdata=0.
- Reset mid-transaction aborts immediately to idle with these same output values.
- Request acceptance:
  - Accepted on a clk edge with ready=1 and start_w|start_r.
  - If both are high, the write wins.
  - ready drops the next cycle.
  - Starts while busy are ignored.
  - addr/wdata are latched at acceptance; later input changes have no effect.
- Timing base: a quarter counter counts QUARTER clocks; every line change happens on a quarter boundary.
- Start condition, 2 quarters: (sioc=1, out=1), then (sioc=1, out=0).
- Each bit, 4 quarters: (sioc=0, set SIOD), (sioc=0), (sioc=1), (sioc=1).
  - SIOD changes only while sioc=0.
  - Read bits are sampled from siod_in on the first clk of the 4th quarter.
- Phase = 8 bits MSB first + 9th bit:
  - Write phases: 9th bit has oe=0 (don't-care/ACK, ignored, no error reporting).
  - Read data phase: oe=0 for the 8 data bits; 9th bit is NA, driven oe=1, out=1.
- Stop condition, 3 quarters: (sioc=0, out=0), (sioc=1, out=0), (sioc=1, out=1).
- States: IDLE, START, BITS, STOP, with phase/bit counters; sequence selected by op.
- Write sequence: START, WR_ID, addr, wdata, STOP.
  - Total 2 + 27*4 + 3 = 113 quarters.
- Read sequence: START, WR_ID, addr, STOP, START, RD_ID, data-in, STOP.
  - Total 2*(2 + 18*4 + 3) = 154 quarters.
- Completion:
  - ready returns to 1 on the clk after the last stop quarter ends.
  - rdata is updated in the same cycle as ready rises, never earlier; it is unchanged by writes.
- Back-to-back: a start asserted in the same cycle ready rises is accepted; idle outputs are held at least that one cycle.
- siod_oe=0 only during the write 9th bits and the read data bits; driven at all other times.

Decomposition:
- Shared package sccb_pkg holds:
  - state enum
  - default IDs 8'h42/8'h43
  - quarter counts per start, bit and stop
- Natural sub-module: sccb_quarter_tick (QUARTER divider, one-cycle tick output, synchronous clear on reset/accept).
- The OV7670 init register table and the request sequencer stay outside this block.

Test Plan:
- Reset then idle 20 cycles -> ready=1, sioc=1, siod_oe=1, siod_out=1, rdata=0 throughout.
- Write, QUARTER=4, addr=8'h12, wdata=8'h80 -> decoded SIOD bytes 42,12,80 on sioc rising edges; oe=0 on each 9th bit; valid start/stop edges; ready low exactly 113*4 cycles.
- Read, QUARTER=4, addr=8'h0A, slave model returns 8'h76 -> bytes 42,0A, stop, start, 43; oe=0 for 8 data bits; NA driven 1; rdata=8'h76 when ready rises; busy 154*4 cycles.
- start_w and start_r together, then start_w pulses while busy -> exactly one write transaction occurs; the busy pulses are ignored.
- Change addr/wdata mid-write -> transmitted bytes equal the latched values.
- Assert reset mid-read -> next cycle idle outputs, ready=1, rdata keeps 0; a new write then completes normally.

Source files
------------

// File: rtl/sccb_pkg.sv
// Shared types and constants for the SCCB master: FSM states, default device IDs,
// quarter counts per bus element and the per-bit SIOD drive helper.
package sccb_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_BITS,
    S_STOP
  } state_t;

  localparam logic [7:0] DEF_WR_ID = 8'h42;
  localparam logic [7:0] DEF_RD_ID = 8'h43;

  localparam int START_QUARTERS = 2;
  localparam int BIT_QUARTERS   = 4;
  localparam int STOP_QUARTERS  = 3;
  localparam int BITS_PER_PHASE = 9;

  // Returns {oe, out} for bit bit_idx of a phase; index 8 is the 9th (ACK/NA) bit.
  function automatic logic [1:0] bit_drive(input logic [7:0] byte_v,
                                           input logic [3:0] bit_idx,
                                           input logic       rx_phase);
    logic [2:0] sel;
    sel = 3'd7 - bit_idx[2:0];
    if (bit_idx == 4'd8) begin
      return rx_phase ? 2'b11 : 2'b01;
    end else if (rx_phase) begin
      return 2'b01;
    end else begin
      return {1'b1, byte_v[sel]};
    end
  endfunction

endpackage

// File: rtl/sccb_master_if.sv
// Request handshake and SCCB pad signals between the camera controller and the SCCB master.
interface sccb_master_if;
  logic       start_w;
  logic       start_r;
  logic [7:0] addr;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       ready;
  logic       sioc;
  logic       siod_oe;
  logic       siod_out;
  logic       siod_in;

  modport master (
    input  start_w, start_r, addr, wdata, siod_in,
    output rdata, ready, sioc, siod_oe, siod_out
  );

  modport slave (
    output start_w, start_r, addr, wdata, siod_in,
    input  rdata, ready, sioc, siod_oe, siod_out
  );
endinterface

// File: rtl/sccb_quarter_tick.sv
// Quarter-period divider: tick is high for the last clk of every QUARTER-clk quarter.
module sccb_quarter_tick #(
  parameter int QUARTER = 63
) (
  input  logic clk,
  input  logic clr,
  output logic tick
);

  localparam int CW = (QUARTER > 2) ? $clog2(QUARTER) : 1;

  logic [CW-1:0] cnt;

  // Clearing on accept makes the first quarter of a transaction a full QUARTER clocks.
  always_ff @(posedge clk) begin
    if (clr || cnt == CW'(QUARTER - 1)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = (cnt == CW'(QUARTER - 1));

endmodule

// File: rtl/sccb_master.sv
// SCCB (OV7670) master: one 3-phase register write or a 2-phase write plus
// 2-phase read per request, with SIOD split into oe/out/in.
module sccb_master
  import sccb_pkg::*;
#(
  parameter int         QUARTER = 63,
  parameter logic [7:0] WR_ID   = DEF_WR_ID,
  parameter logic [7:0] RD_ID   = DEF_RD_ID
) (
  input  logic          clk,
  input  logic          reset,
  sccb_master_if.master bus
);

  state_t     state;
  logic [1:0] qidx;
  logic [3:0] bit_cnt;
  logic [1:0] byte_idx;
  logic       seg;
  logic       op_rd;
  logic       samp;
  logic [7:0] addr_q;
  logic [7:0] wdata_q;
  logic [7:0] rx;
  logic [7:0] rdata_r;
  logic       ready_r;
  logic       sioc_r;
  logic       oe_r;
  logic       out_r;
  logic       tick;
  logic       accept;
  logic       rx_phase;
  logic [1:0] last_idx;

  assign accept   = (state == S_IDLE) && (bus.start_w || bus.start_r);
  assign rx_phase = seg && (byte_idx == 2'd1);
  assign last_idx = op_rd ? 2'd1 : 2'd2;

  sccb_quarter_tick #(.QUARTER(QUARTER)) u_tick (
    .clk  (clk),
    .clr  (reset || accept),
    .tick (tick)
  );

  // Segment 0 carries WR_ID/addr/wdata; segment 1 (read only) sends RD_ID then receives.
  function automatic logic [7:0] pick_byte(input logic seg_v, input logic [1:0] idx);
    if (seg_v) begin
      return RD_ID;
    end
    case (idx)
      2'd0:    return WR_ID;
      2'd1:    return addr_q;
      default: return wdata_q;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      qidx     <= '0;
      bit_cnt  <= '0;
      byte_idx <= '0;
      seg      <= 1'b0;
      op_rd    <= 1'b0;
      samp     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rx       <= '0;
      rdata_r  <= '0;
      ready_r  <= 1'b1;
      sioc_r   <= 1'b1;
      oe_r     <= 1'b1;
      out_r    <= 1'b1;
    end else begin
      samp <= 1'b0;
      if (samp) begin
        rx <= {rx[6:0], bus.siod_in};
      end
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            state   <= S_START;
            ready_r <= 1'b0;
            op_rd   <= !bus.start_w;
            addr_q  <= bus.addr;
            if (bus.start_w) begin
              wdata_q <= bus.wdata;
            end
            qidx    <= '0;
            seg     <= 1'b0;
            sioc_r  <= 1'b1;
            oe_r    <= 1'b1;
            out_r   <= 1'b1;
          end
        end
        S_START: begin
          if (tick) begin
            if (qidx != 2'(START_QUARTERS - 1)) begin
              qidx  <= qidx + 2'd1;
              out_r <= 1'b0;
            end else begin
              state         <= S_BITS;
              qidx          <= '0;
              bit_cnt       <= '0;
              byte_idx      <= '0;
              sioc_r        <= 1'b0;
              {oe_r, out_r} <= bit_drive(pick_byte(seg, 2'd0), 4'd0, 1'b0);
            end
          end
        end
        S_BITS: begin
          if (tick) begin
            if (qidx != 2'(BIT_QUARTERS - 1)) begin
              qidx <= qidx + 2'd1;
              if (qidx == 2'd1) begin
                sioc_r <= 1'b1;
              end
              // Arms the sample for the first clk of the 4th quarter.
              if (qidx == 2'd2) begin
                samp <= rx_phase && (bit_cnt != 4'd8);
              end
            end else if (bit_cnt != 4'(BITS_PER_PHASE - 1)) begin
              qidx          <= '0;
              bit_cnt       <= bit_cnt + 4'd1;
              sioc_r        <= 1'b0;
              {oe_r, out_r} <= bit_drive(pick_byte(seg, byte_idx), bit_cnt + 4'd1, rx_phase);
            end else if (byte_idx != last_idx) begin
              qidx          <= '0;
              bit_cnt       <= '0;
              byte_idx      <= byte_idx + 2'd1;
              sioc_r        <= 1'b0;
              {oe_r, out_r} <= bit_drive(pick_byte(seg, byte_idx + 2'd1), 4'd0,
                                         seg && (byte_idx == 2'd0));
            end else begin
              state  <= S_STOP;
              qidx   <= '0;
              sioc_r <= 1'b0;
              oe_r   <= 1'b1;
              out_r  <= 1'b0;
            end
          end
        end
        S_STOP: begin
          if (tick) begin
            if (qidx == 2'd0) begin
              qidx   <= 2'd1;
              sioc_r <= 1'b1;
            end else if (qidx != 2'(STOP_QUARTERS - 1)) begin
              qidx  <= qidx + 2'd1;
              out_r <= 1'b1;
            end else if (op_rd && !seg) begin
              state <= S_START;
              seg   <= 1'b1;
              qidx  <= '0;
            end else begin
              state   <= S_IDLE;
              ready_r <= 1'b1;
              if (op_rd) begin
                rdata_r <= rx;
              end
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.rdata    = rdata_r;
  assign bus.ready    = ready_r;
  assign bus.sioc     = sioc_r;
  assign bus.siod_oe  = oe_r;
  assign bus.siod_out = out_r;

endmodule

// File: tb/tb_sccb_master.sv
// Self-checking bench for sccb_master: table-driven transactions with a bus-decoding
// scoreboard, plus hand-written sequences for contention, latching, back-to-back and reset.
module tb_sccb_master;
  import sccb_pkg::*;

  localparam int Q        = 4;
  localparam int WR_CYC   = 113 * Q;
  localparam int RD_CYC   = 154 * Q;
  localparam int EV_START = 2 << 24;
  localparam int EV_STOP  = 3 << 24;

  typedef struct {
    logic       rd;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] rval;
    int         cycles;
    logic [7:0] exp_rdata;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic slave_drv = 1'b1;
  logic mon_en = 1'b0;
  logic [7:0] rd_val = 8'h00;
  logic [7:0] last_rd = 8'h00;
  int total = 0;
  int bad = 0;
  int exp_q[$];
  vec_t vecs[6];

  always #5 clk = ~clk;

  sccb_master_if bus();

  sccb_master #(.QUARTER(Q), .WR_ID(8'h42), .RD_ID(8'h43)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Open-drain line with pull-up: released SIOD reads the slave model's value.
  assign bus.siod_in = bus.siod_oe ? bus.siod_out : slave_drv;

  function automatic int evByte(input logic [7:0] b, input logic [7:0] m,
                                input logic noe, input logic nln);
    return (1 << 24) | (int'(m) << 16) | (int'(noe) << 9) | (int'(nln) << 8) | int'(b);
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic scoreboard(input int code);
    if (exp_q.size() == 0) begin
      checkOutput("sb_unexpected", code, 0);
    end else begin
      checkOutput("sb_event", code, exp_q.pop_front());
    end
  endtask

  task automatic applyStimulus(input logic rd, input logic [7:0] a, input logic [7:0] d,
                               input logic [7:0] rv);
    bus.addr    = a;
    bus.wdata   = d;
    bus.start_w = !rd;
    bus.start_r = rd;
    exp_q.push_back(EV_START);
    exp_q.push_back(evByte(8'h42, 8'hFF, 1'b0, 1'b1));
    exp_q.push_back(evByte(a, 8'hFF, 1'b0, 1'b1));
    if (rd) begin
      rd_val = rv;
      exp_q.push_back(EV_STOP);
      exp_q.push_back(EV_START);
      exp_q.push_back(evByte(8'h43, 8'hFF, 1'b0, 1'b1));
      exp_q.push_back(evByte(rv, 8'h00, 1'b1, 1'b1));
    end else begin
      exp_q.push_back(evByte(d, 8'hFF, 1'b0, 1'b1));
    end
    exp_q.push_back(EV_STOP);
  endtask

  task automatic waitDone(input int exp_cycles, input logic [7:0] prev_rd, input string name);
    int n = 0;
    int early = 0;
    while (n <= 3000) begin
      @(negedge clk);
      if (bus.ready === 1'b1) break;
      n++;
      if (bus.rdata !== prev_rd) early++;
    end
    checkOutput({name, "_busy"}, n, exp_cycles);
    checkOutput({name, "_rdata_early"}, early, 0);
  endtask

  task automatic checkIdle(input int n, input logic [7:0] exp_rd, input string name);
    int errs = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (!(bus.ready === 1'b1 && bus.sioc === 1'b1 && bus.siod_oe === 1'b1 &&
            bus.siod_out === 1'b1 && bus.rdata === exp_rd)) errs++;
    end
    checkOutput(name, errs, 0);
  endtask

  // Bus decoder and slave model: START/STOP on SIOD edges while SIOC is high,
  // bits on SIOC rising edges; after START+RD_ID the slave drives rd_val.
  logic       prev_sioc = 1'b1;
  logic       prev_line = 1'b1;
  logic       after_start = 1'b0;
  logic       slave_active = 1'b0;
  logic [8:0] sh_d;
  logic [8:0] sh_oe;
  int         bitpos = 0;

  always @(negedge clk) begin
    logic ln;
    ln = bus.siod_in;
    if (!mon_en) begin
      bitpos       = 0;
      after_start  = 1'b0;
      slave_active = 1'b0;
      slave_drv    = 1'b1;
    end else begin
      if (prev_sioc && bus.sioc && prev_line && !ln) begin
        scoreboard(EV_START);
        bitpos      = 0;
        after_start = 1'b1;
      end else if (prev_sioc && bus.sioc && !prev_line && ln) begin
        scoreboard(EV_STOP);
        bitpos       = 0;
        after_start  = 1'b0;
        slave_active = 1'b0;
      end else if (!prev_sioc && bus.sioc) begin
        sh_d  = {sh_d[7:0], ln};
        sh_oe = {sh_oe[7:0], bus.siod_oe};
        bitpos++;
        if (bitpos == 9) begin
          scoreboard(evByte(sh_d[8:1], sh_oe[8:1], sh_oe[0], sh_d[0]));
          bitpos       = 0;
          slave_active = after_start && (sh_d[8:1] == 8'h43);
          after_start  = 1'b0;
        end
      end
      if (!bus.sioc) begin
        slave_drv = (slave_active && bitpos < 8) ? rd_val[3'(7 - bitpos)] : 1'b1;
      end
    end
    prev_sioc = bus.sioc;
    prev_line = ln;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0] = '{rd: 1'b0, addr: 8'h12, wdata: 8'h80, rval: 8'h00, cycles: WR_CYC, exp_rdata: 8'h00};
    vecs[1] = '{rd: 1'b1, addr: 8'h0A, wdata: 8'h00, rval: 8'h76, cycles: RD_CYC, exp_rdata: 8'h76};
    vecs[2] = '{rd: 1'b0, addr: 8'hFF, wdata: 8'h00, rval: 8'h00, cycles: WR_CYC, exp_rdata: 8'h76};
    vecs[3] = '{rd: 1'b1, addr: 8'h55, wdata: 8'h00, rval: 8'hA5, cycles: RD_CYC, exp_rdata: 8'hA5};
    vecs[4] = '{rd: 1'b0, addr: 8'h00, wdata: 8'hFF, rval: 8'h00, cycles: WR_CYC, exp_rdata: 8'hA5};
    vecs[5] = '{rd: 1'b1, addr: 8'h3C, wdata: 8'h00, rval: 8'h00, cycles: RD_CYC, exp_rdata: 8'h00};

    bus.start_w = 1'b0;
    bus.start_r = 1'b0;
    bus.addr    = 8'h00;
    bus.wdata   = 8'h00;
    reset       = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_ready", int'(bus.ready), 1);
    checkOutput("rst_sioc", int'(bus.sioc), 1);
    checkOutput("rst_oe", int'(bus.siod_oe), 1);
    checkOutput("rst_out", int'(bus.siod_out), 1);
    checkOutput("rst_rdata", int'(bus.rdata), 0);
    reset = 1'b0;
    checkIdle(20, 8'h00, "idle_20");
    mon_en = 1'b1;

    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      applyStimulus(vecs[i].rd, vecs[i].addr, vecs[i].wdata, vecs[i].rval);
      @(posedge clk);
      #1;
      bus.start_w = 1'b0;
      bus.start_r = 1'b0;
      waitDone(vecs[i].cycles, last_rd, $sformatf("vec%0d", i));
      checkOutput($sformatf("vec%0d_rdata", i), int'(bus.rdata), int'(vecs[i].exp_rdata));
      last_rd = vecs[i].exp_rdata;
    end
    checkOutput("sb_drain_vec", exp_q.size(), 0);

    // Both starts together: the write wins; pulses while busy are ignored.
    @(negedge clk);
    applyStimulus(1'b0, 8'h33, 8'h44, 8'h00);
    bus.start_r = 1'b1;
    @(posedge clk);
    #1;
    bus.start_w = 1'b0;
    bus.start_r = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      bus.start_w = 1'b1;
      bus.start_r = (k % 2 == 0);
      bus.addr    = 8'(8'hE0 + k);
      @(negedge clk);
      bus.start_w = 1'b0;
      bus.start_r = 1'b0;
    end
    waitDone(WR_CYC - 10, last_rd, "both");
    checkIdle(20, last_rd, "after_both");
    checkOutput("sb_drain_both", exp_q.size(), 0);

    // Inputs changed mid-write must not reach the bus.
    @(negedge clk);
    applyStimulus(1'b0, 8'h5A, 8'hC3, 8'h00);
    @(posedge clk);
    #1;
    bus.start_w = 1'b0;
    repeat (40) @(negedge clk);
    bus.addr  = 8'hA5;
    bus.wdata = 8'h3C;
    waitDone(WR_CYC - 40, last_rd, "latch");
    checkOutput("sb_drain_latch", exp_q.size(), 0);

    // A start held through busy is accepted in the cycle ready rises.
    @(negedge clk);
    applyStimulus(1'b0, 8'h11, 8'h22, 8'h00);
    @(posedge clk);
    #1;
    bus.start_w = 1'b0;
    @(negedge clk);
    applyStimulus(1'b0, 8'h66, 8'h77, 8'h00);
    waitDone(WR_CYC - 1, last_rd, "b2b_first");
    checkOutput("b2b_idle_sioc", int'(bus.sioc), 1);
    checkOutput("b2b_idle_out", int'(bus.siod_out), 1);
    @(posedge clk);
    #1;
    bus.start_w = 1'b0;
    waitDone(WR_CYC, last_rd, "b2b_second");
    checkOutput("sb_drain_b2b", exp_q.size(), 0);

    // Reset in the middle of a read aborts straight to idle.
    @(negedge clk);
    applyStimulus(1'b1, 8'h0A, 8'h00, 8'h76);
    @(posedge clk);
    #1;
    bus.start_r = 1'b0;
    repeat (400) @(negedge clk);
    mon_en = 1'b0;
    reset  = 1'b1;
    @(negedge clk);
    checkOutput("mid_rst_ready", int'(bus.ready), 1);
    checkOutput("mid_rst_sioc", int'(bus.sioc), 1);
    checkOutput("mid_rst_oe", int'(bus.siod_oe), 1);
    checkOutput("mid_rst_out", int'(bus.siod_out), 1);
    checkOutput("mid_rst_rdata", int'(bus.rdata), 0);
    reset = 1'b0;
    exp_q.delete();
    last_rd = 8'h00;
    checkIdle(10, 8'h00, "post_rst_idle");
    mon_en = 1'b1;
    @(negedge clk);
    applyStimulus(1'b0, 8'h3A, 8'h04, 8'h00);
    @(posedge clk);
    #1;
    bus.start_w = 1'b0;
    waitDone(WR_CYC, 8'h00, "post_rst_wr");
    checkOutput("post_rst_rdata", int'(bus.rdata), 0);
    checkOutput("sb_drain_final", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
